// File: rtl/huffman_bit_packer.sv
// rtl/huffman_bit_packer.sv - packs variable-length codewords MSB-first into bytes
// A 64-bit accumulator feeds a small {last,data} FIFO; a flush pads the tail byte.
module huffman_bit_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_LEN    = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [31:0] in_code,
  input  logic [5:0]  in_length,
  input  logic        in_flush,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        flush_done,
  output logic [6:0]  bits_pending,
  output logic        overflow,
  output logic        len_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_acc;
  logic [6:0]  r_fill;
  logic [8:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_overflow;
  logic        r_len_err;

  logic        w_empty;
  logic        w_full;
  logic        w_fifo_pop;
  logic        w_push;
  logic        w_push_last;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_len_ok;
  logic        w_add;
  logic [31:0] w_mask;
  logic [31:0] w_code;
  logic [6:0]  w_fill_shift;
  logic [63:0] w_acc_shift;
  logic [5:0]  w_place_sh;
  logic [63:0] w_code_pos;
  logic [63:0] w_acc_next;
  logic [6:0]  w_fill_next;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_fifo_pop = !w_empty && out_ready;

  // Full is judged on registered pointers, so a same-cycle pop only helps next cycle.
  assign w_push      = !w_full && ((r_fill >= 7'd8) || ((r_state == S_FLUSH) && (r_fill != 7'd0)));
  assign w_push_last = (r_state == S_FLUSH) && (r_fill <= 7'd8);

  assign w_in_ready = (r_state == S_RUN) && (r_fill <= 7'd32);
  assign w_accept   = in_valid && w_in_ready;
  assign w_len_ok   = ({1'b0, in_length} <= 7'(MAX_LEN));
  assign w_add      = w_accept && w_len_ok && (in_length != 6'd0);

  assign w_mask = (in_length >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << in_length[4:0]) - 32'd1);
  assign w_code = in_code & w_mask;

  assign w_fill_shift = w_push ? ((r_fill >= 7'd8) ? (r_fill - 7'd8) : 7'd0) : r_fill;
  assign w_acc_shift  = w_push ? {r_acc[55:0], 8'd0} : r_acc;

  // Shift of 64 - fill' - len (mod 64) lands the code's msb at bit 63 - fill'.
  assign w_place_sh  = 6'd0 - w_fill_shift[5:0] - in_length;
  assign w_code_pos  = {32'd0, w_code} << w_place_sh;
  assign w_acc_next  = w_add ? (w_acc_shift | w_code_pos) : w_acc_shift;
  assign w_fill_next = w_add ? (w_fill_shift + {1'b0, in_length}) : w_fill_shift;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:   if (in_flush) w_state_next = S_FLUSH;
      S_FLUSH: if (w_fill_next == 7'd0) w_state_next = S_DRAIN;
      S_DRAIN: if (w_empty) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_RUN;
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= S_RUN;
      r_acc      <= 64'd0;
      r_fill     <= 7'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_fill  <= w_fill_next;
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fifo_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (in_valid && !w_in_ready) r_overflow <= 1'b1;
      if (w_accept && !w_len_ok)   r_len_err  <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_push_last, r_acc[63:56]};
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = !w_empty;
  assign out_data     = w_empty ? 8'd0 : r_mem[r_rd_ptr[AW-1:0]][7:0];
  assign out_last     = w_empty ? 1'b0 : r_mem[r_rd_ptr[AW-1:0]][8];
  assign flush_done   = (r_state == S_DONE);
  assign bits_pending = r_fill;
  assign overflow     = r_overflow;
  assign len_err      = r_len_err;

endmodule

// File: doc/huffman_bit_packer.md
Name: huffman_bit_packer

Overview:
- Sits directly downstream of the Huffman coder and consumes its code/length/enable stream.
- Concatenates variable-length codewords, MSB-first, into a contiguous bitstream.
- Emits the stream as bytes through a small output FIFO with valid/ready handshake.
- A flush request zero-pads the final partial byte, tags the last byte, and reports completion.

Parameters:
FIFO_DEPTH, 8, output byte FIFO entries (power of two, >=2)
MAX_LEN, 32, largest legal codeword length in bits (fixed by in_code width)

Ports:
clock  input  1  system clock; all logic rising-edge
resetn  input  1  synchronous active-low reset
in_valid  input  1  codeword present this cycle (coder enable_out)
in_code  input  32  codeword, LSB-aligned; bit in_length-1 is sent first
in_length  input  6  codeword length 0..32
in_flush  input  1  request end-of-stream padding/drain
in_ready  output  1  packer can accept a full 32-bit codeword this cycle
out_data  output  8  head byte of output FIFO
out_last  output  1  head byte is final byte of a flushed stream
out_valid  output  1  output FIFO non-empty
out_ready  input  1  consumer takes head byte when out_valid & out_ready
flush_done  output  1  one-cycle pulse: flush complete, FIFO empty
bits_pending  output  7  bits held in accumulator, 0..64
overflow  output  1  sticky: in_valid seen while in_ready=0
len_err  output  1  sticky: accepted in_valid with in_length>32

Behaviour:
- Synchronous reset (resetn=0 at edge):
  - accumulator, fill, FIFO pointers, state, overflow, len_err all cleared.
  - in_ready=1 in state RUN after reset; every other output is 0.
- Accumulator:
  - acc[63:0], MSB-aligned; the next byte out is acc[63:56]. fill = bits_pending.
  - Unused low bits of acc are always zero.
  - Masking: in_code bits at or above in_length are ignored.
- Input acceptance:
  - in_ready = (state==RUN) & (fill<=32), decoded from registered state.
  - Accept = in_valid & in_ready. In the same edge, the masked code is OR'd into acc at bit position 63-fill' (msb of the code).
  - fill' is fill after any same-cycle pop.
  - length 0: accepted, no change.
  - length 33..63: word dropped, len_err set.
  - in_valid with in_ready=0: word dropped, overflow set. Neither flag clears except by reset.
- Pop to FIFO:
  - Condition: fifo_not_full & (fill>=8, or state==FLUSH & fill>0).
  - acc shifts left 8 with zero fill; fill -= min(8, fill).
  - The pushed byte is acc[63:56], so a partial byte is zero-padded in its low bits.
- Simultaneous pop and accept in one cycle:
  - fill_next = fill - popped + in_length.
  - The new code is placed relative to the post-shift acc.
- Latency: a codeword accepted at edge E0 produces its first byte in the FIFO at E1, so out_valid rises after E1. No bubbles while FIFO space exists: one byte per clock.
- Output FIFO:
  - 9 bits wide ({last,data}), FIFO_DEPTH entries. Circular pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
  - Push and pop in the same cycle are legal when full or empty-with-push; on full, the pop frees a slot for the next cycle only.
  - out_data and out_last are 0 when empty.
- FSM:
  - RUN: in_flush=1 -> FLUSH. An in_valid accepted in the same cycle is included in the stream before padding.
  - FLUSH: in_ready=0; pops continue. The byte that takes fill to 0 is pushed with last=1. When fill==0 after that push -> DRAIN. If fill was already 0 on entry -> DRAIN directly, and no last byte is produced.
  - DRAIN: wait for FIFO empty -> DONE.
  - DONE: flush_done=1 for exactly one cycle -> RUN.
  - in_flush outside RUN is ignored.
- Reset asserted mid-operation: all state is discarded at that edge and no flush_done is emitted.

Test Plan:
- Coding convention used below: {code,len} is fed with in_valid=1 for one cycle each.
- Basic packing: feed {0b101,3}, then {0b11110,5}, out_ready=1 -> a single byte 0xBE, last=0; bits_pending returns to 0.
- Full word plus flush: feed {0xDEADBEEF,32}, then in_flush -> bytes DE, AD, BE, EF on consecutive cycles. The first byte has out_valid 2 cycles after accept; last=1 only on EF; flush_done pulses once after EF is taken.
- Partial pad: feed {0x1,1}, then in_flush -> a single byte 0x80 with last=1, then flush_done. A flush with nothing pending -> flush_done, no byte.
- Backpressure/overflow:
  - Hold out_ready=0 and feed {0xA5A5A5A5,32} repeatedly -> FIFO fills with 8 bytes, fill reaches >32, in_ready=0.
  - One extra in_valid -> overflow=1, that word is absent from the stream.
  - Release out_ready -> the byte stream equals the accepted words exactly, and in_ready reasserts when fill<=32.
- Length edge cases:
  - {0xFF,0} -> no bytes, no flags.
  - {0xFFFFFFFF,40} -> dropped, len_err=1.
  - {0xFFFFFFF0,4}, then {0x0F,4} -> 0x0F (masking of high bits).
- Reset mid-flush:
  - Feed {0xDEADBEEF,32}, start flush, then pull resetn=0 after 2 bytes have been pushed -> out_valid, bits_pending, flags and flush_done are all 0 next cycle.
  - Normal packing resumes after resetn=1.
